// File: rtl/bp_writeback_control_if.sv
// Buffer-read and DDR write-FIFO signals of the BP writeback drain path.
// The master side (the controller) issues reads and pushes 512-bit words.
interface bp_writeback_control_if #(
  parameter int ADDR_LEN   = 16,
  parameter int DATA_LEN   = 32,
  parameter int BUFFER_NUM = 64
);
  logic [ADDR_LEN-1:0]            BP_rd_addr;
  logic [BUFFER_NUM-1:0]          BP_rd_en;
  logic [DATA_LEN*BUFFER_NUM-1:0] BP_rd_data;
  logic                           ddr_fifo_full;
  logic                           ddr_fifo_wr;
  logic [DATA_LEN*16-1:0]         ddr_fifo_data;

  modport master (
    output BP_rd_addr, BP_rd_en, ddr_fifo_wr, ddr_fifo_data,
    input  BP_rd_data, ddr_fifo_full
  );

  modport slave (
    input  BP_rd_addr, BP_rd_en, ddr_fifo_wr, ddr_fifo_data,
    output BP_rd_data, ddr_fifo_full
  );
endinterface

// File: rtl/bp_writeback_control.sv
// Drains BP bank groups into the DDR write FIFO, one 16-lane 512-bit word per read,
// and hands the DDR write engine its start address and byte length.
module bp_writeback_control #(
  parameter int DDR_ADDR_LEN = 32,
  parameter int ADDR_LEN     = 16,
  parameter int DATA_LEN     = 32,
  parameter int SINGLE_LEN   = 24,
  parameter int BUFFER_NUM   = 64,
  parameter int READ_LAT     = 2,
  parameter int SKID_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    conf,
  input  logic [DDR_ADDR_LEN-1:0] ddr_st_addr,
  input  logic [ADDR_LEN-1:0]     BP_st_addr,
  input  logic [1:0]              BP_st_num,
  input  logic [2:0]              num_lines,
  input  logic [SINGLE_LEN-1:0]   Line_width,
  output logic [DDR_ADDR_LEN-1:0] ddr_st_addr_out,
  output logic [SINGLE_LEN-1:0]   ddr_len,
  output logic                    ddr_conf,
  output logic                    idle,
  bp_writeback_control_if.master  bus
);

  localparam int LANES    = 16;
  localparam int WORD_LEN = DATA_LEN * LANES;
  localparam int PTR_W    = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int CNT_W    = $clog2(SKID_DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN
  } state_t;

  state_t state_reg, state_next;

  logic [ADDR_LEN-1:0]     st_addr_cfg_reg;
  logic [2:0]              lines_cfg_reg;
  logic [SINGLE_LEN-1:0]   width_cfg_reg;
  logic [DDR_ADDR_LEN-1:0] ddr_st_addr_reg;
  logic [SINGLE_LEN-1:0]   ddr_len_reg;
  logic                    ddr_conf_reg;

  logic [1:0]              bank_reg, bank_next;
  logic [ADDR_LEN-1:0]     addr_reg, addr_next;
  logic [SINGLE_LEN-1:0]   word_cnt_reg, word_cnt_next;
  logic [2:0]              line_cnt_reg, line_cnt_next;

  logic                    pipe_valid_reg [READ_LAT];
  logic [1:0]              pipe_bank_reg  [READ_LAT];

  logic [WORD_LEN-1:0]     skid_mem [SKID_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]        skid_count_reg;

  logic                    wr_reg;
  logic [WORD_LEN-1:0]     data_reg;

  logic                    cfg_ok, accept, issue, last_word, last_line;
  logic [CNT_W-1:0]        inflight;
  logic [CNT_W:0]          occupancy;
  logic [SINGLE_LEN-1:0]   len_words;
  logic                    ret_valid;
  logic [1:0]              ret_bank;
  logic [WORD_LEN-1:0]     ret_word, head_word;
  logic                    head_valid, pop, bypass, push, pop_mem;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign cfg_ok    = (num_lines != 3'd0) && (num_lines <= 3'd4) && (Line_width != '0);
  assign accept    = (state_reg == S_IDLE) && conf && cfg_ok;
  assign len_words = Line_width * SINGLE_LEN'(num_lines);

  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LAT; i++) begin
      inflight = inflight + CNT_W'(pipe_valid_reg[i]);
    end
  end

  // Credit rule: a read may only launch if its word is guaranteed a skid slot on return.
  assign occupancy = {1'b0, skid_count_reg} + {1'b0, inflight};
  assign issue     = (state_reg == S_READ) && (occupancy < (CNT_W + 1)'(SKID_DEPTH));
  assign last_word = (word_cnt_reg == width_cfg_reg - 1'b1);
  assign last_line = (line_cnt_reg == lines_cfg_reg - 3'd1);

  always_comb begin
    state_next    = state_reg;
    bank_next     = bank_reg;
    addr_next     = addr_reg;
    word_cnt_next = word_cnt_reg;
    line_cnt_next = line_cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          state_next    = S_READ;
          bank_next     = BP_st_num;
          addr_next     = BP_st_addr;
          word_cnt_next = '0;
          line_cnt_next = '0;
        end
      end
      S_READ: begin
        if (issue) begin
          if (last_word) begin
            word_cnt_next = '0;
            bank_next     = bank_reg + 2'd1;
            addr_next     = st_addr_cfg_reg;
            line_cnt_next = line_cnt_reg + 3'd1;
            if (last_line) begin
              state_next = S_DRAIN;
            end
          end else begin
            word_cnt_next = word_cnt_reg + 1'b1;
            addr_next     = addr_reg + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if ((inflight == '0) && (skid_count_reg == '0)) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      bank_reg     <= '0;
      addr_reg     <= '0;
      word_cnt_reg <= '0;
      line_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      bank_reg     <= bank_next;
      addr_reg     <= addr_next;
      word_cnt_reg <= word_cnt_next;
      line_cnt_reg <= line_cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_addr_cfg_reg <= '0;
      lines_cfg_reg   <= '0;
      width_cfg_reg   <= '0;
      ddr_st_addr_reg <= '0;
      ddr_len_reg     <= '0;
      ddr_conf_reg    <= 1'b0;
    end else begin
      ddr_conf_reg <= accept;
      if (accept) begin
        st_addr_cfg_reg <= BP_st_addr;
        lines_cfg_reg   <= num_lines;
        width_cfg_reg   <= Line_width;
        ddr_st_addr_reg <= ddr_st_addr;
        ddr_len_reg     <= len_words << 6;
      end
    end
  end

  // Bank tag travels with each read so the returning lanes can be picked out.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < READ_LAT; i++) begin
        pipe_valid_reg[i] <= 1'b0;
        pipe_bank_reg[i]  <= '0;
      end
    end else begin
      pipe_valid_reg[0] <= issue;
      pipe_bank_reg[0]  <= bank_reg;
      for (int i = 1; i < READ_LAT; i++) begin
        pipe_valid_reg[i] <= pipe_valid_reg[i-1];
        pipe_bank_reg[i]  <= pipe_bank_reg[i-1];
      end
    end
  end

  assign ret_valid = pipe_valid_reg[READ_LAT-1];
  assign ret_bank  = pipe_bank_reg[READ_LAT-1];

  generate
    for (genvar gi = 0; gi < BUFFER_NUM; gi++) begin : g_rd_en
      assign bus.BP_rd_en[gi] = issue && (bank_reg == 2'(gi % 4));
    end
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign ret_word[gi*DATA_LEN +: DATA_LEN] =
        (ret_bank == 2'd0) ? bus.BP_rd_data[(4*gi+0)*DATA_LEN +: DATA_LEN] :
        (ret_bank == 2'd1) ? bus.BP_rd_data[(4*gi+1)*DATA_LEN +: DATA_LEN] :
        (ret_bank == 2'd2) ? bus.BP_rd_data[(4*gi+2)*DATA_LEN +: DATA_LEN] :
                             bus.BP_rd_data[(4*gi+3)*DATA_LEN +: DATA_LEN];
    end
  endgenerate

  assign bus.BP_rd_addr = issue ? addr_reg : '0;

  // An arriving word may go straight to the output register when the skid is empty.
  assign head_valid = (skid_count_reg != '0) || ret_valid;
  assign head_word  = (skid_count_reg != '0) ? skid_mem[rd_ptr_reg] : ret_word;
  assign pop        = head_valid && !bus.ddr_fifo_full;
  assign bypass     = pop && (skid_count_reg == '0);
  assign push       = ret_valid && !bypass;
  assign pop_mem    = pop && (skid_count_reg != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      skid_mem[wr_ptr_reg] <= ret_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      skid_count_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (pop_mem) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      case ({push, pop_mem})
        2'b10:   skid_count_reg <= skid_count_reg + 1'b1;
        2'b01:   skid_count_reg <= skid_count_reg - 1'b1;
        default: skid_count_reg <= skid_count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_reg   <= 1'b0;
      data_reg <= '0;
    end else begin
      wr_reg <= pop;
      if (pop) begin
        data_reg <= head_word;
      end
    end
  end

  assign bus.ddr_fifo_wr   = wr_reg;
  assign bus.ddr_fifo_data = data_reg;
  assign ddr_st_addr_out   = ddr_st_addr_reg;
  assign ddr_len           = ddr_len_reg;
  assign ddr_conf          = ddr_conf_reg;
  assign idle              = (state_reg == S_IDLE);

endmodule

// File: tb/tb_bp_writeback_control.sv
// Bench for bp_writeback_control: directed jobs plus random jobs, checked against a
// queue-based model of the words and reads each job must produce.
module tb_bp_writeback_control;

  localparam int RL = 2;

  logic        clk = 1'b0;
  logic        rst, conf;
  logic [31:0] ddr_st_addr;
  logic [15:0] BP_st_addr;
  logic [1:0]  BP_st_num;
  logic [2:0]  num_lines;
  logic [23:0] Line_width;
  logic [31:0] ddr_st_addr_out;
  logic [23:0] ddr_len;
  logic        ddr_conf, idle;

  always #5 clk = ~clk;

  bp_writeback_control_if #(.ADDR_LEN(16), .DATA_LEN(32), .BUFFER_NUM(64)) bus ();

  bp_writeback_control #(
    .DDR_ADDR_LEN(32), .ADDR_LEN(16), .DATA_LEN(32), .SINGLE_LEN(24),
    .BUFFER_NUM(64), .READ_LAT(RL), .SKID_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .conf(conf), .ddr_st_addr(ddr_st_addr),
    .BP_st_addr(BP_st_addr), .BP_st_num(BP_st_num), .num_lines(num_lines),
    .Line_width(Line_width), .ddr_st_addr_out(ddr_st_addr_out), .ddr_len(ddr_len),
    .ddr_conf(ddr_conf), .idle(idle), .bus(bus)
  );

  // Buffer model: enabled buffers answer {index, address} READ_LAT cycles later.
  logic [63:0] en_d   [RL];
  logic [15:0] addr_d [RL];

  always @(posedge clk) begin
    en_d[0]   <= bus.BP_rd_en;
    addr_d[0] <= bus.BP_rd_addr;
    for (int i = 1; i < RL; i++) begin
      en_d[i]   <= en_d[i-1];
      addr_d[i] <= addr_d[i-1];
    end
  end

  always_comb begin
    bus.BP_rd_data = '0;
    for (int b = 0; b < 64; b++) begin
      bus.BP_rd_data[b*32 +: 32] = en_d[RL-1][b] ? {16'(b), addr_d[RL-1]} : {16'hBAD0, 16'(b)};
    end
  end

  logic [511:0] exp_words [$];
  logic [79:0]  exp_issues [$];
  int           n_vec = 0, n_err = 0;
  int           cyc = 0;
  bit           bp_on = 1'b0, in_reset = 1'b0;
  logic [511:0] last_data = '0;
  int           wr_count, conf_count, conf_cyc_seen, first_wr_cyc, last_wr_cyc, lat;
  logic [23:0]  len_seen;
  logic [31:0]  addr_seen;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [79:0] issue_of(input int bank, input int addr);
    logic [63:0] mask;
    mask = '0;
    for (int j = 0; j < 16; j++) mask[bank + 4*j] = 1'b1;
    return {mask, 16'(addr)};
  endfunction

  task automatic plan_job(input int sa, input int sn, input int nl, input int lw);
    logic [511:0] w;
    int b, a;
    for (int l = 0; l < nl; l++) begin
      b = (sn + l) % 4;
      for (int k = 0; k < lw; k++) begin
        a = (sa + k) & 16'hFFFF;
        exp_issues.push_back(issue_of(b, a));
        for (int j = 0; j < 16; j++) w[j*32 +: 32] = {16'(b + 4*j), 16'(a)};
        exp_words.push_back(w);
      end
    end
  endtask

  task automatic tick();
    logic full_seen;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    full_seen = bus.ddr_fifo_full;
    if (ddr_conf) begin
      conf_count++;
      conf_cyc_seen = cyc;
      len_seen      = ddr_len;
      addr_seen     = ddr_st_addr_out;
    end
    if (bus.BP_rd_en != '0) begin
      if (exp_issues.size() == 0) check("spurious_issue", {bus.BP_rd_en, bus.BP_rd_addr}, 80'd0);
      else check("issue", {bus.BP_rd_en, bus.BP_rd_addr}, exp_issues.pop_front());
    end
    if (bus.ddr_fifo_wr) begin
      wr_count++;
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
      last_wr_cyc = cyc;
      if (full_seen) check("wr_while_full", bus.ddr_fifo_wr, 0);
      if (exp_words.size() == 0) check("extra_write", bus.ddr_fifo_wr, 0);
      else check("word", bus.ddr_fifo_data, exp_words.pop_front());
    end else if (!in_reset) begin
      check("data_hold", bus.ddr_fifo_data, last_data);
    end
    last_data = bus.ddr_fifo_data;
    bus.ddr_fifo_full = bp_on ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  task automatic run_job(input logic [31:0] da, input int sa, input int sn, input int nl,
                         input int lw, input bit bp, input int busy_at, input int abort_after);
    int start, guard;
    bit aborted;
    exp_words.delete();
    exp_issues.delete();
    wr_count = 0; conf_count = 0; conf_cyc_seen = -1; first_wr_cyc = -1; last_wr_cyc = -1;
    plan_job(sa, sn, nl, lw);
    bp_on       = bp;
    ddr_st_addr = da;
    BP_st_addr  = 16'(sa);
    BP_st_num   = 2'(sn);
    num_lines   = 3'(nl);
    Line_width  = 24'(lw);
    conf        = 1'b1;
    start       = cyc;
    tick();
    conf    = 1'b0;
    guard   = 0;
    aborted = 1'b0;
    while (!idle && guard < 3000) begin
      if (busy_at > 0 && guard == busy_at) begin
        conf       = 1'b1;
        Line_width = 24'd5;
        num_lines  = 3'd1;
        BP_st_num  = BP_st_num + 2'd1;
        BP_st_addr = 16'h7777;
      end
      if (abort_after > 0 && wr_count == abort_after) begin
        rst = 1'b1; in_reset = 1'b1;
        tick();
        rst = 1'b0; in_reset = 1'b0;
        check("abort_wr", bus.ddr_fifo_wr, 0);
        check("abort_rd_en", bus.BP_rd_en, 0);
        check("abort_idle", idle, 1);
        check("abort_data", bus.ddr_fifo_data, 0);
        aborted = 1'b1;
        break;
      end
      tick();
      conf = 1'b0;
      guard++;
    end
    bp_on = 1'b0;
    bus.ddr_fifo_full = 1'b0;
    if (aborted) begin
      exp_words.delete();
      exp_issues.delete();
      return;
    end
    check("job_done", 32'(guard < 3000), 1);
    check("writes", wr_count, nl * lw);
    check("conf_pulses", conf_count, 1);
    check("conf_cycle", conf_cyc_seen - start, 1);
    check("ddr_len", len_seen, 24'(nl * lw * 64));
    check("ddr_addr", addr_seen, da);
    check("idle_after_last_wr", cyc - last_wr_cyc, 1);
    check("words_left", exp_words.size(), 0);
    lat = first_wr_cyc - start;
    $display("job addr=%h bank=%0d lines=%0d width=%0d bp=%0d writes=%0d", da, sn, nl, lw, bp, wr_count);
  endtask

  initial begin
    int tbl_nl [4] = '{2, 0, 5, 7};
    int tbl_lw [4] = '{0, 4, 4, 1};
    rst = 1'b1; conf = 1'b0; in_reset = 1'b1;
    ddr_st_addr = '0; BP_st_addr = '0; BP_st_num = '0; num_lines = '0; Line_width = '0;
    bus.ddr_fifo_full = 1'b0;
    tick();
    tick();
    check("rst_idle", idle, 1);
    check("rst_wr", bus.ddr_fifo_wr, 0);
    check("rst_rd_en", bus.BP_rd_en, 0);
    check("rst_rd_addr", bus.BP_rd_addr, 0);
    check("rst_conf", ddr_conf, 0);
    check("rst_len", ddr_len, 0);
    check("rst_addr_out", ddr_st_addr_out, 0);
    check("rst_data", bus.ddr_fifo_data, 0);
    rst = 1'b0; in_reset = 1'b0;
    tick();

    run_job(32'h1000, 16'h10, 1, 2, 8, 1'b0, 0, 0);
    run_job(32'h2000, 16'h40, 3, 4, 2, 1'b0, 0, 0);
    run_job(32'h3000, 16'h80, 2, 1, 16, 1'b1, 0, 0);

    for (int t = 0; t < 4; t++) begin
      conf_count = 0;
      num_lines  = 3'(tbl_nl[t]);
      Line_width = 24'(tbl_lw[t]);
      conf = 1'b1;
      tick();
      conf = 1'b0;
      tick();
      tick();
      check("illegal_conf_pulse", conf_count, 0);
      check("illegal_conf_idle", idle, 1);
    end

    run_job(32'h4000, 16'h100, 0, 2, 20, 1'b0, 3, 0);
    run_job(32'h5000, 16'h200, 1, 2, 16, 1'b0, 0, 5);
    tick();
    run_job(32'h5000, 16'h200, 1, 2, 16, 1'b0, 0, 0);

    run_job(32'h6000, 16'h300, 2, 1, 1, 1'b0, 0, 0);
    check("min_latency", lat, 2 + RL);

    for (int k = 0; k < 8; k++) begin
      run_job($urandom, $urandom_range(0, 65535), $urandom_range(0, 3), $urandom_range(1, 4),
              $urandom_range(1, 12), 1'($urandom_range(0, 1)), 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
